// File: rtl/rom_loader_if.sv
// Byte-stream ingress and ROM write-port bundle for rom_loader.
// slave = the loader; master = the host link / ROM side that faces it.
interface rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  rom_we,
    input  rom_addr,
    input  rom_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output rom_we,
    output rom_addr,
    output rom_wdata
  );
endinterface

// File: rtl/rom_loader.sv
// Loads a length-prefixed big-endian 16-bit word image into the instruction ROM and holds the CPU
// in reset until the image is complete. Define ROM_LOADER_CHECKSUM_EN to require a trailing checksum.
module rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic         clk,
  input  logic         reset,
  rom_loader_if.slave  bus,
  input  logic         reload,
  output logic         cpu_reset,
  output logic         loading,
  output logic         error,
  output logic         done
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_RUN,
    S_ERR
  } state_t;

  // Where the stream goes once the last word (or an empty image) has been received.
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHK_HI;
`else
  localparam state_t END_STATE = S_RUN;
`endif

  // Largest legal word count is the full ROM depth; 17 bits so ADDR_W up to 16 fits.
  localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic              w_in_ready;
  logic              w_accept;
  logic [15:0]       w_len;
  logic [7:0]        r_hi;
  logic [15:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [15:0]       r_rom_wdata;
  logic              r_done;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       r_sum;
`endif

  assign w_len    = {r_hi, bus.in_data};
  assign w_accept = bus.in_valid && w_in_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_LEN_HI: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          if (w_len == 16'd0)                w_next = END_STATE;
          else if ({1'b0, w_len} > LEN_MAX)  w_next = S_ERR;
          else                               w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = (r_count == 16'd1) ? END_STATE : S_DATA_HI;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK_HI: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_CHK_LO;
      end
      S_CHK_LO: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = (w_len == r_sum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN, S_ERR: begin
        if (reload) w_next = S_LEN_HI;
      end
      default: w_next = S_LEN_HI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LEN_HI;
      r_hi        <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_wdata <= '0;
      r_done      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      r_done  <= (w_next == S_RUN) && (r_state != S_RUN);
      case (r_state)
        S_LEN_HI: begin
          if (w_accept) r_hi <= bus.in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
          r_sum <= '0;
`endif
        end
        S_LEN_LO: begin
          if (w_accept) r_count <= w_len;
        end
        S_DATA_HI: begin
          if (w_accept) r_hi <= bus.in_data;
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_we        <= 1'b1;
            r_rom_addr  <= r_addr;
            r_rom_wdata <= w_len;
            r_addr      <= r_addr + ADDR_W'(1);
            r_count     <= r_count - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum       <= r_sum + w_len;
`endif
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHK_HI: begin
          if (w_accept) r_hi <= bus.in_data;
        end
`endif
        S_RUN, S_ERR: begin
          if (reload) begin
            r_addr  <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rom_we    = r_we;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_wdata = r_rom_wdata;
  assign cpu_reset     = (r_state != S_RUN);
  assign loading       = (r_state != S_RUN) && (r_state != S_ERR);
  assign error         = (r_state == S_ERR);
  assign done          = r_done;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader (ADDR_W = 4): stimulus queues expected ROM writes, a negedge
// monitor pops and compares them. Define ROM_LOADER_CHECKSUM_EN for the checksum build.
module tb_rom_loader;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_reset;
  logic loading;
  logic error;
  logic done;

  rom_loader_if #(.ADDR_W(ADDR_W)) u_if ();

  rom_loader #(.ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (u_if),
    .reload    (reload),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .error     (error),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int unsigned       cyc;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         m_e;
  int unsigned total    = 0;
  int unsigned bad      = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  logic [15:0] img_sum;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [15:0]       m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expectation and land the cycle after its low byte.
  always @(negedge clk) begin
    if (u_if.rom_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(u_if.rom_addr), 32'hFFFF_FFFF);
      end else begin
        m_e = sb_q.pop_front();
        check("wr_addr", 32'(u_if.rom_addr), 32'(m_e.addr));
        check("wr_data", 32'(u_if.rom_wdata), 32'(m_e.data));
        check("wr_latency", cyc, m_e.cyc);
      end
      m_addr = u_if.rom_addr;
      m_data = u_if.rom_wdata;
    end else begin
      check("hold_addr", 32'(u_if.rom_addr), 32'(m_addr));
      check("hold_data", 32'(u_if.rom_wdata), 32'(m_data));
    end
    if (reset) begin
      m_addr = '0;
      m_data = '0;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      u_if.in_valid = 1'b0;
      u_if.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    u_if.in_data  = b;
    u_if.in_valid = 1'b1;
    while (!u_if.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!u_if.in_ready) check("ready_timeout", 32'(u_if.in_ready), 32'd1);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n, input int gap);
    img_sum = 16'h0000;
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [ADDR_W-1:0] addr, input int gap);
    wr_t e;
    send_byte(hi, gap);
    send_byte(lo, gap);
    e.addr = addr;
    e.data = {hi, lo};
    e.cyc  = cyc;
    sb_q.push_back(e);
    img_sum = img_sum + {hi, lo};
  endtask

  task automatic expect_run(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd0);
    check({tag, "_loading"}, 32'(loading), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    exp_done++;
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_error"}, 32'(error), 32'd1);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd0);
    check({tag, "_loading"}, 32'(loading), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // With the checksum build the image is closed by the big-endian sum of its words.
  task automatic finish_ok(input string tag);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(img_sum[15:8], 0);
    send_byte(img_sum[7:0], 0);
`endif
    expect_run(tag);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_in_ready", 32'(u_if.in_ready), 32'd1);
    check("reload_loading", 32'(loading), 32'd1);
    check("reload_error", 32'(error), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    reload        = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    img_sum       = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_rom_we", 32'(u_if.rom_we), 32'd0);
    check("rst_rom_addr", 32'(u_if.rom_addr), 32'd0);
    check("rst_rom_wdata", 32'(u_if.rom_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(u_if.in_ready), 32'd1);

    // Two words at full rate.
    send_len(16'd2, 0);
    send_word(8'h12, 8'h34, 4'd0, 0);
    send_word(8'hAB, 8'hCD, 4'd1, 0);
    finish_ok("img2");
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("run_cpu_reset_stays", 32'(cpu_reset), 32'd0);

    // Reload from RUN with a one-word image.
    do_reload();
    send_len(16'd1, 0);
    send_word(8'h55, 8'hAA, 4'd0, 0);
    finish_ok("reload_img");

    // Empty image: no writes at all.
    do_reload();
    send_len(16'd0, 0);
    finish_ok("empty_img");

    // One word past ROM depth is rejected, then recovery via reload.
    do_reload();
    send_len(16'd17, 0);
    expect_err("overflow");
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 32'(error), 32'd1);
    do_reload();
    send_len(16'd1, 0);
    send_word(8'h00, 8'h07, 4'd0, 0);
    finish_ok("after_err");

    // Exactly ROM depth; reload held high mid-load must be ignored.
    do_reload();
    send_len(16'd16, 0);
    reload = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) reload = 1'b0;
      send_word({4'(i), 4'(15 - i)}, 8'(i) ^ 8'hA5, 4'(i), 0);
    end
    finish_ok("full_depth");

    // Gappy stream interrupted by reset after the third data byte; reset beats in_valid.
    do_reload();
    send_len(16'd3, $urandom_range(0, 3));
    send_word(8'h12, 8'h34, 4'd0, $urandom_range(1, 3));
    send_byte(8'h56, $urandom_range(1, 3));
    reset         = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h00;
    @(posedge clk); #1;
    reset         = 1'b0;
    u_if.in_valid = 1'b0;
    check("midrst_rom_we", 32'(u_if.rom_we), 32'd0);
    check("midrst_rom_wdata", 32'(u_if.rom_wdata), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_in_ready", 32'(u_if.in_ready), 32'd1);
    check("midrst_loading", 32'(loading), 32'd1);
    send_len(16'd1, 0);
    send_word(8'hFF, 8'hFF, 4'd0, 0);
    finish_ok("after_rst");

`ifdef ROM_LOADER_CHECKSUM_EN
    // 0x0001 + 0x0002 = 0x0003 matches; 0x0004 does not, but the words stay written.
    do_reload();
    send_len(16'd2, 0);
    send_word(8'h00, 8'h01, 4'd0, 0);
    send_word(8'h00, 8'h02, 4'd1, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    expect_run("chk_good");
    do_reload();
    send_len(16'd2, 0);
    send_word(8'h00, 8'h01, 4'd0, 0);
    send_word(8'h00, 8'h02, 4'd1, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    expect_err("chk_bad");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    check("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the instruction ROM that the program counter reads.
- Receives a byte stream over a valid/ready handshake, assembles 16-bit big-endian instruction words, and writes them to consecutive ROM addresses starting at 0.
- Holds the CPU in reset while loading; releases it once the image is complete.
- Sits between the host byte link (UART receiver or testbench) and the ROM write port.

Parameters:
- ADDR_W, 15, ROM address width; ROM depth = 2^ADDR_W words.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- reload  input  1  pulse: restart loading from RUN or ERR
- rom_we  output  1  ROM write enable, one-cycle pulse per word
- rom_addr  output  ADDR_W  ROM write address
- rom_wdata  output  16  ROM write data
- cpu_reset  output  1  held high whenever the FSM is not in RUN
- loading  output  1  high in LEN_HI through the last data or checksum byte
- error  output  1  high in ERR
- done  output  1  one-cycle pulse on entry to RUN

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the posedge of clk.
- Values on reset:
  - state = LEN_HI, word count = 0, address counter = 0.
  - rom_we = 0, rom_addr = 0, rom_wdata = 0.
  - cpu_reset = 1, loading = 1, error = 0, done = 0, in_ready = 1.
- Handshake:
  - A byte transfers on a posedge where in_valid && in_ready.
  - in_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO; 0 in RUN and ERR.
  - The source may hold in_valid indefinitely; there is no backpressure inside the receive states.
- State sequence:
  - LEN_HI -> LEN_LO: first byte is the high byte of the 16-bit word count N.
  - LEN_LO -> second byte is the low byte of N. Then:
    - N == 0 -> RUN, or CHK_HI with CHECKSUM_EN.
    - N > 2^ADDR_W -> ERR.
    - Otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO: latch the high byte.
  - DATA_LO: on accept, the next cycle drives rom_we = 1, rom_wdata = {hi, lo}, rom_addr = current address. The address then increments and the word count decrements.
    - Count reaches 0 -> RUN, or CHK_HI with CHECKSUM_EN.
    - Otherwise -> DATA_HI.
  - RUN: cpu_reset = 0, loading = 0; done pulses for the single cycle of entry.
  - RUN or ERR, reload = 1 -> LEN_HI. cpu_reset = 1 from the next cycle; address and count are cleared.
  - reload is ignored in all other states.
- Write latency: one cycle after the DATA_LO byte is accepted; exactly one write per word.
- Back-to-back words are supported. Minimum spacing is 2 cycles per word at full rate.
- Address: ADDR_W-bit counter, never wraps.
  - N == 2^ADDR_W writes addresses 0..2^ADDR_W-1 and then stops.
  - The counter value after the final write is don't-care.
- rom_addr and rom_wdata hold their last values when rom_we = 0.
- Reset mid-load: returns to LEN_HI, discards any partial word, and issues no write that cycle.
- Simultaneous reset and in_valid: reset wins; the byte is not consumed.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or N == 0), states CHK_HI and CHK_LO receive a big-endian 16-bit checksum.
  - The expected value is the mod-2^16 sum of all written words; the accumulator clears in LEN_HI.
  - Match -> RUN.
  - Mismatch -> ERR: cpu_reset stays 1, error = 1.
  - ROM contents are already written and are not rolled back.
- Undefined: CHK states and the accumulator are absent. ERR is reachable only through length overflow.

Test Plan:
- Stream 00 02 12 34 AB CD, in_valid held high -> writes (0, 0x1234) then (1, 0xABCD), one cycle after each low byte. done pulses once, cpu_reset falls, in_ready = 0.
- Stream 00 00 -> no rom_we; RUN entered after the LEN_LO byte. With checksum: requires 00 00 as the checksum.
- ADDR_W = 4, stream length 00 11 (17) -> ERR: error = 1, cpu_reset = 1, no writes. Then reload followed by 00 01 00 07 -> single write (0, 0x0007), then RUN.
- Stream 00 03 with random in_valid gaps, and reset asserted after the 3rd data byte -> no write for the partial word. A fresh 00 01 FF FF stream writes (0, 0xFFFF).
- In RUN, reload pulse plus new image 00 01 55 AA -> cpu_reset high from the next cycle; write (0, 0x55AA); done pulses again.
- With checksum: 00 02 00 01 00 02 00 03 -> RUN. The same stream ending 00 04 -> ERR, error = 1.
